// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, WB/M control
// field bit positions and the EX/MEM memory-access FSM state encoding.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Bit positions inside the 2-bit WB and M control fields
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HELD   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller for the EX/MEM stage.
// Tracks whether an access is outstanding, produces the memory request and
// the busy/hold indication, and defers a flush that arrives while busy.
module mem_access_fsm
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic flush_i,
  input  logic mem_ack_i,
  input  logic mem_op_i,     // incoming EX instruction is a load or store
  output logic load_o,       // payload registers capture this cycle
  output logic flush_eff_o,  // capture as a bubble this cycle
  output logic mem_req_o,
  output logic mem_busy_o
);

  mem_state_e state_reg;
  mem_state_e state_next;
  logic       flush_pend_reg;
  logic       start_access;

  // Capture / bubble decision and whether the captured op needs memory
  always_comb begin
    load_o       = !(stall_i | mem_busy_o);
    flush_eff_o  = flush_i | flush_pend_reg;
    start_access = load_o & !flush_eff_o & mem_op_i;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; an in-flight access only leaves ACCESS on ack
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_access) state_next = ACCESS;
      end
      ACCESS: begin
        if (mem_ack_i) begin
          if (stall_i)           state_next = HELD;
          else if (start_access) state_next = ACCESS;
          else                   state_next = IDLE;
        end
      end
      HELD: begin
        if (load_o) state_next = start_access ? ACCESS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: purely from state and ack, never from stall_i
  always_comb begin
    mem_req_o  = (state_reg == ACCESS);
    mem_busy_o = (state_reg == ACCESS) & !mem_ack_i;
  end

  // Flush seen while busy is remembered until the next capture consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     flush_pend_reg <= 1'b0;
    else if (load_o)                flush_pend_reg <= 1'b0;
    else if (flush_i && mem_busy_o) flush_pend_reg <= 1'b1;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory handshake and forwarding taps.
// Optional build macro EX_MEM_PERF_EN adds a saturating count of cycles
// spent stalled on data memory (mem_stall_cnt_o).
module ex_mem_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            WB_i,
  input  logic [1:0]            M_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [1:0]            WB_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  valid_o,
  output logic                  FW_RegWrite_o,
  output logic [REG_ADDR_W-1:0] FW_rd_o,
  output logic                  mem_busy_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [DATA_W-1:0]     mem_stall_cnt_o
`endif
);

  logic [1:0]            wb_reg;
  logic [1:0]            m_reg;
  logic [DATA_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  valid_reg;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  load;
  logic                  flush_eff;
  logic                  mem_op;

  assign mem_op = M_i[M_MEMREAD] | M_i[M_MEMWRITE];

  mem_access_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .mem_ack_i  (mem_ack_i),
    .mem_op_i   (mem_op),
    .load_o     (load),
    .flush_eff_o(flush_eff),
    .mem_req_o  (mem_req_o),
    .mem_busy_o (mem_busy_o)
  );

  // Payload capture; a bubble keeps the data but clears control and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg    <= '0;
      m_reg     <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      addr_reg  <= alu_result_i;
      wdata_reg <= wdata_i;
      rd_reg    <= rd_i;
      if (flush_eff) begin
        wb_reg    <= '0;
        m_reg     <= '0;
        valid_reg <= 1'b0;
      end else begin
        wb_reg    <= WB_i;
        m_reg     <= M_i;
        valid_reg <= 1'b1;
      end
    end
  end

  // Load data is latched whenever a read request is acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata_reg <= '0;
    else if (mem_req_o && mem_ack_i && !m_reg[M_MEMWRITE])
      rdata_reg <= mem_rdata_i;
  end

`ifdef EX_MEM_PERF_EN
  logic [DATA_W-1:0] stall_cnt_reg;

  // Saturating count of memory-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= '0;
    else if (mem_busy_o && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign mem_stall_cnt_o = stall_cnt_reg;
`endif

  assign WB_o          = wb_reg;
  assign mem_we_o      = m_reg[M_MEMWRITE];
  assign addr_o        = addr_reg;
  assign mem_wdata_o   = wdata_reg;
  assign rdata_o       = rdata_reg;
  assign rd_o          = rd_reg;
  assign valid_o       = valid_reg;
  assign FW_RegWrite_o = wb_reg[WB_REGWRITE] & valid_reg;
  assign FW_rd_o       = rd_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: captured instructions are queued as
// expected records when driven and popped when the stage loads them.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  WB_i, M_i;
  logic [31:0] alu_result_i, wdata_i, mem_rdata_i;
  logic [4:0]  rd_i;
  logic        stall_i, flush_i, mem_ack_i;
  logic [1:0]  WB_o;
  logic        mem_req_o, mem_we_o, valid_o, FW_RegWrite_o, mem_busy_o;
  logic [31:0] addr_o, mem_wdata_o, rdata_o;
  logic [4:0]  rd_o, FW_rd_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0] mem_stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  wb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .WB_i(WB_i), .M_i(M_i),
    .alu_result_i(alu_result_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .stall_i(stall_i), .flush_i(flush_i), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .WB_o(WB_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .addr_o(addr_o), .mem_wdata_o(mem_wdata_o),
    .rdata_o(rdata_o), .rd_o(rd_o), .valid_o(valid_o),
    .FW_RegWrite_o(FW_RegWrite_o), .FW_rd_o(FW_rd_o),
    .mem_busy_o(mem_busy_o)
`ifdef EX_MEM_PERF_EN
    , .mem_stall_cnt_o(mem_stall_cnt_o)
`endif
  );

  function automatic exp_t get_obs();
    exp_t o;
    o.wb = WB_o; o.we = mem_we_o; o.addr = addr_o;
    o.wdata = mem_wdata_o; o.rd = rd_o; o.valid = valid_o;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one EX instruction and queue what the stage should hold once it loads it
  task automatic issue(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input bit bubble);
    exp_t e;
    WB_i = wb; M_i = m; alu_result_i = a; wdata_i = wd; rd_i = rd;
    e.wb = bubble ? 2'b00 : wb;
    e.we = bubble ? 1'b0 : m[0];
    e.addr = a; e.wdata = wd; e.rd = rd; e.valid = !bubble;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    WB_i = '0; M_i = '0; alu_result_i = '0; wdata_i = '0; rd_i = '0;
    stall_i = 0; flush_i = 0; mem_ack_i = 0; mem_rdata_i = '0;
    tick(); tick();
    checks++;
    if ({WB_o, mem_req_o, mem_we_o, addr_o, mem_wdata_o, rdata_o, rd_o, valid_o,
         FW_RegWrite_o, FW_rd_o, mem_busy_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero output (valid=%b req=%b addr=%h), want all 0",
                         valid_o, mem_req_o, addr_o);
    end
`ifdef EX_MEM_PERF_EN
    checks++;
    if (mem_stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", mem_stall_cnt_o);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_alu_op();
    exp_t e, o;
    issue(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL alu_capture: got %h want %h", o, e); end
    checks++;
    if ({FW_RegWrite_o, FW_rd_o, mem_req_o} !== {1'b1, 5'd5, 1'b0}) begin
      errors++; $display("FAIL alu_fwd: got fw_we=%b fw_rd=%0d req=%b want 1 5 0",
                         FW_RegWrite_o, FW_rd_o, mem_req_o);
    end
    $display("alu_op: addr=%h rd=%0d valid=%b", addr_o, rd_o, valid_o);
  endtask

  task automatic test_load_wait();
    exp_t e, o;
    int busy_cnt = 0;
    mem_ack_i = 0;
    issue(2'b11, 2'b10, 32'h100, 32'h0, 5'd7, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL load_capture: got %h want %h", o, e); end
    checks++;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL load_req: got %b want 1", mem_req_o); end
    issue(2'b10, 2'b00, 32'h2000, 32'h0, 5'd9, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_busy_o === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (addr_o !== 32'h100) begin errors++; $display("FAIL load_hold: addr got %h want 100", addr_o); end
    mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_busy_o} !== 2'b10) begin
      errors++; $display("FAIL load_ack_cycle: req/busy got %b want 10", {mem_req_o, mem_busy_o});
    end
    tick();
    mem_ack_i = 0;
    checks++;
    if (busy_cnt !== 3) begin errors++; $display("FAIL load_busy_len: got %0d want 3", busy_cnt); end
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rdata_o); end
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL load_next_capture: got %h want %h", o, e); end
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b want 0", mem_req_o); end
`ifdef EX_MEM_PERF_EN
    checks++;
    if (mem_stall_cnt_o !== 32'd3) begin errors++; $display("FAIL perf_cnt: got %0d want 3", mem_stall_cnt_o); end
`endif
    $display("load_wait: busy_cycles=%0d rdata=%h", busy_cnt, rdata_o);
  endtask

  task automatic test_store_zero_wait();
    exp_t e, o;
    issue(2'b00, 2'b01, 32'h40, 32'hCAFE, 5'd0, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL store_capture: got %h want %h", o, e); end
    checks++;
    if ({mem_req_o, mem_we_o} !== 2'b11) begin
      errors++; $display("FAIL store_req: req/we got %b want 11", {mem_req_o, mem_we_o});
    end
    issue(2'b10, 2'b00, 32'h44, 32'h0, 5'd2, 0);
    mem_ack_i = 1; mem_rdata_i = 32'h55555555;
    @(negedge clk);
    checks++;
    if (mem_busy_o !== 1'b0) begin errors++; $display("FAIL store_busy: got %b want 0", mem_busy_o); end
    tick();
    mem_ack_i = 0;
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL store_next_capture: got %h want %h", o, e); end
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL store_req_len: got %b want 0", mem_req_o); end
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata_hold: got %h want deadbeef", rdata_o); end
    $display("store_zero_wait: addr=%h wdata=%h", e.addr, e.wdata);
  endtask

  task automatic test_flush_busy();
    exp_t e, o;
    issue(2'b11, 2'b10, 32'h200, 32'h0, 5'd3, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL flush_load_capture: got %h want %h", o, e); end
    issue(2'b11, 2'b10, 32'h204, 32'h0, 5'd6, 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_busy_o} !== 2'b11) begin
      errors++; $display("FAIL flush_no_abort: req/busy got %b want 11", {mem_req_o, mem_busy_o});
    end
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h11112222;
    tick();
    mem_ack_i = 0;
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL flush_bubble: got %h want %h", o, e); end
    checks++;
    if ({mem_req_o, FW_RegWrite_o} !== 2'b00) begin
      errors++; $display("FAIL flush_bubble_ctl: req/fw_we got %b want 00", {mem_req_o, FW_RegWrite_o});
    end
    checks++;
    if (rdata_o !== 32'h11112222) begin errors++; $display("FAIL flush_rdata: got %h want 11112222", rdata_o); end
    issue(2'b10, 2'b00, 32'h208, 32'h0, 5'd8, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL flush_cleared: got %h want %h", o, e); end
    $display("flush_busy: bubble captured, then valid=%b", valid_o);
  endtask

  task automatic test_ack_stall();
    exp_t e, o;
    issue(2'b11, 2'b10, 32'h300, 32'h0, 5'd4, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL stall_load_capture: got %h want %h", o, e); end
    issue(2'b10, 2'b00, 32'h3000, 32'h0, 5'd10, 0);
    stall_i = 1; mem_ack_i = 1; mem_rdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_busy_o} !== 2'b10) begin
      errors++; $display("FAIL stall_ack_cycle: req/busy got %b want 10", {mem_req_o, mem_busy_o});
    end
    tick();
    mem_ack_i = 0;
    checks++;
    if ({mem_req_o, addr_o, rdata_o} !== {1'b0, 32'h300, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL stall_held: req=%b addr=%h rdata=%h want 0 300 a5a5a5a5",
                         mem_req_o, addr_o, rdata_o);
    end
    for (int i = 0; i < 2; i++) begin
      mem_ack_i = 1; mem_rdata_i = 32'h0BADF00D;
      @(negedge clk);
      checks++;
      if ({mem_req_o, mem_busy_o} !== 2'b00) begin
        errors++; $display("FAIL stall_no_rereq: req/busy got %b want 00", {mem_req_o, mem_busy_o});
      end
      tick();
    end
    mem_ack_i = 0;
    checks++;
    if ({addr_o, rdata_o} !== {32'h300, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL stall_hold_out: addr=%h rdata=%h want 300 a5a5a5a5", addr_o, rdata_o);
    end
    stall_i = 0;
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL stall_release_capture: got %h want %h", o, e); end
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stall_release_req: got %b want 0", mem_req_o); end
    $display("ack_stall: released, addr=%h", addr_o);
  endtask

  task automatic test_reset_mid_access();
    exp_t e, o;
    issue(2'b11, 2'b10, 32'h400, 32'h0, 5'd1, 0);
    tick();
    e = sb_q.pop_front(); o = get_obs();
    checks++;
    if ({o, mem_req_o} !== {e, 1'b1}) begin
      errors++; $display("FAIL rst_load_capture: got %h req=%b want %h req=1", o, mem_req_o, e);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({WB_o, mem_req_o, mem_we_o, addr_o, mem_wdata_o, rdata_o, rd_o, valid_o,
         FW_RegWrite_o, FW_rd_o, mem_busy_o} !== '0) begin
      errors++; $display("FAIL rst_async: req=%b busy=%b valid=%b addr=%h rdata=%h want all 0",
                         mem_req_o, mem_busy_o, valid_o, addr_o, rdata_o);
    end
`ifdef EX_MEM_PERF_EN
    checks++;
    if (mem_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", mem_stall_cnt_o); end
`endif
    @(negedge clk); rst_n = 1'b1;
    sb_q.delete();
    $display("reset_mid_access: outputs cleared");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_zero_wait();
    test_flush_busy();
    test_ack_stall();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage of the 5-stage MIPS core, directly downstream of the ID/EX register and the ALU. It captures the EX-stage result, store data, destination register and the remaining WB/M control bits. It drives the data-memory request/acknowledge handshake and stalls the upstream pipeline while a memory access is outstanding. It also exports RegWrite/rd to the forwarding unit.

## Interface
- No parameters; widths are fixed by the shared package.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- WB_i  in  2  [1] RegWrite, [0] MemtoReg, from the ID/EX WB field.
- M_i  in  2  [1] MemRead, [0] MemWrite, from the ID/EX M field.
- alu_result_i  in  32  ALU output; becomes the memory address.
- wdata_i  in  32  forwarded rt value, used as store data.
- rd_i  in  5  destination register, after the RegDst mux.
- stall_i  in  1  external hold from the hazard unit.
- flush_i  in  1  insert a bubble instead of the EX instruction.
- mem_ack_i  in  1  data memory has completed the current request.
- mem_rdata_i  in  32  load data, valid when mem_ack_i is high.
- WB_o  out  2  registered WB field, for MEM/WB.
- mem_req_o  out  1  request to data memory.
- mem_we_o  out  1  write enable; equals the registered MemWrite.
- addr_o  out  32  registered ALU result.
- mem_wdata_o  out  32  registered store data.
- rdata_o  out  32  latched load data.
- rd_o  out  5  registered destination register.
- valid_o  out  1  stage holds a real (non-bubble) instruction.
- FW_RegWrite_o  out  1  WB_o[1] & valid_o, to the forwarding unit.
- FW_rd_o  out  5  rd_o, to the forwarding unit.
- mem_busy_o  out  1  stage cannot accept a new instruction this cycle.

## Operation
- hold = stall_i | mem_busy_o. On a rising edge with !hold, all payload registers load from the inputs and valid_o is set to 1.
- flush_i while !hold: payload loads, but WB_o, M and valid_o load as 0 (bubble).
- flush_i while mem_busy_o: the flush is latched into flush_pend. It is applied at the first load after busy clears, and flush_pend is then cleared.
- An in-flight access is never aborted.
- FSM states:
  - IDLE → ACCESS on a load of a valid instruction with MemRead|MemWrite.
  - ACCESS: mem_req_o=1; mem_busy_o = !mem_ack_i.
  - ACCESS + ack + !stall_i: go to ACCESS if the newly loaded instruction is a memory op, otherwise IDLE.
  - ACCESS + ack + stall_i → HELD.
  - HELD: mem_req_o=0, mem_busy_o=0. On stall release, the new load takes the same transition as from IDLE.
- rdata_o captures mem_rdata_i on every cycle with mem_req_o & mem_ack_i & !mem_we_o. Otherwise rdata_o holds.
- mem_ack_i outside ACCESS is ignored.

## Timing
- Reset values: all outputs 0; FSM state IDLE; flush_pend 0.
- Latency: EX inputs appear on the outputs 1 cycle after capture.
- mem_req_o asserts in the cycle after the memory op is captured.
- Zero-wait memory (ack in the first ACCESS cycle) gives 0 stall cycles.
- N wait cycles give mem_busy_o high for exactly N cycles.
- mem_busy_o and mem_req_o are combinational from the state and mem_ack_i. There is no path from stall_i to mem_req_o.
- Reset asserted mid-access: the request drops immediately and the stage returns to reset values.

## Configuration
- EX_MEM_PERF_EN defined: adds output `mem_stall_cnt_o` (32-bit).
  - It increments every cycle mem_busy_o=1 and saturates at 0xFFFFFFFF.
  - It resets to 0.
- Not defined: the port and the counter are absent; there is no other difference.

## Structure
- The shared package `mips_pkg` holds:
  - the WB/M field bit-index constants (RegWrite=1, MemtoReg=0, MemRead=1, MemWrite=0);
  - the FSM state typedef {IDLE, ACCESS, HELD};
  - REG_ADDR_W=5 and DATA_W=32.
- One sub-module, `mem_access_fsm`: state, flush_pend, mem_req_o and mem_busy_o. The payload registers stay in the top module.

## Test plan
- Reset, then a valid ALU op: WB_i=2'b10, M_i=0, alu_result_i=0x1234, rd_i=5. Required next cycle: valid_o=1, addr_o=0x1234, FW_RegWrite_o=1, FW_rd_o=5, mem_req_o=0.
- Load with ack after 3 wait cycles, mem_rdata_i=0xDEADBEEF. Required: mem_busy_o high for exactly 3 cycles, rdata_o=0xDEADBEEF after the ack edge, next instruction captured on the ack edge.
- Store with zero-wait ack: addr_o=0x40, mem_wdata_o=0xCAFE, mem_we_o=1. Required: mem_req_o for 1 cycle, mem_busy_o never asserted.
- flush_i during a busy load. Required: the access completes, then the next captured instruction has valid_o=0, WB_o=0 and no mem_req_o.
- Ack arrives while stall_i=1. Required: state HELD, mem_req_o drops, no re-request, outputs held until stall_i falls.
- rst_n pulled low mid-ACCESS. Required: all outputs 0 asynchronously; with EX_MEM_PERF_EN, mem_stall_cnt_o=0.
